adma_dm_wr_host: RTL and testbench
==================================

Name: adma_dm_wr_host

Overview:
Destination-side write host of the AXI DMA data mover; the write counterpart to the source read host.
- Accepts per-channel write transaction descriptors and issues them on the AXI4 AW channel.
- Streams mover data onto the W channel with generated WLAST.
- Retires B responses, reporting per-channel completion pulses and sticky error flags.

Parameters:
DMA_CHN_NUM, 4, number of DMA channels
DST_ADDR_W, 32, AXI address width
ATX_DST_DATA_W, 256, W data width
ATX_DST_BYTE_AMT, ATX_DST_DATA_W/8, WSTRB width
MST_ID_W, 5, AXI ID width
ATX_LEN_W, 8, AWLEN width
ATX_RESP_W, 2, BRESP width
ATX_NUM_OSTD, DMA_CHN_NUM, maximum outstanding write transactions (AW accepted, B not yet received)
DMA_CHN_NUM_W, clog2(DMA_CHN_NUM) (min 1), derived, not user-set

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
atx_chn_id  in  DMA_CHN_NUM_W  owning channel of descriptor
atx_awid  in  MST_ID_W  descriptor ID
atx_awaddr  in  DST_ADDR_W  descriptor address
atx_awlen  in  ATX_LEN_W  beats-1
atx_awburst  in  2  burst type
atx_vld  in  1  descriptor valid
atx_rdy  out  1  descriptor accept
atx_wdata  in  ATX_DST_DATA_W  write data beat
atx_wdata_vld  in  1  data valid
atx_wdata_rdy  out  1  data accept
atx_done  out  DMA_CHN_NUM  one-cycle completion pulse per channel
atx_dst_err  out  DMA_CHN_NUM  sticky error flag per channel
atx_err_clr  in  DMA_CHN_NUM  clears the matching atx_dst_err bit
m_awid_o / m_awaddr_o / m_awlen_o / m_awburst_o  out  MST_ID_W / DST_ADDR_W / ATX_LEN_W / 2  AW payload
m_awvalid_o  out  1 ; m_awready_i  in  1
m_wdata_o  out  ATX_DST_DATA_W ; m_wstrb_o  out  ATX_DST_BYTE_AMT ; m_wlast_o  out  1
m_wvalid_o  out  1 ; m_wready_i  in  1
m_bid_i  in  MST_ID_W ; m_bresp_i  in  ATX_RESP_W ; m_bvalid_i  in  1 ; m_bready_o  out  1

Behaviour:
Reset
- Asynchronous assertion, synchronous release.
- Clears: AW buffer, length FIFO, tracking table, beat counter, outstanding count, atx_done, atx_dst_err.
- Outputs after reset: m_awvalid_o=0, m_wvalid_o=0, m_wlast_o=0, m_bready_o=0, atx_rdy=0 until the first clock after release.
- Reset mid-operation abandons all in-flight transactions; no done pulses are generated for them.

Accept
- atx_rdy = AW buffer not full & length FIFO not full & ostd_cnt < ATX_NUM_OSTD & no valid tracking entry with id==atx_awid.
- Blocking a duplicate ID makes B matching unique.
- On atx_vld&atx_rdy, the same cycle:
  - push {awid, awaddr, awlen, awburst} into the 2-entry AW buffer;
  - push awlen into the length FIFO (depth ATX_NUM_OSTD);
  - allocate a free tracking entry {valid, id, chn_id};
  - ostd_cnt+1.

AW
- m_ax* are driven from the AW buffer head register.
- m_awvalid_o is held high and the payload held stable until m_awready_i.
- Pop on handshake; with 2 entries, back-to-back issue has no bubble.

W
- W is independent of AW progress: data may precede its AW, which AXI4 allows.
- m_wvalid_o = atx_wdata_vld & length FIFO not empty.
- atx_wdata_rdy = m_wready_i & length FIFO not empty.
- m_wdata_o = atx_wdata, combinational pass-through.
- m_wstrb_o = all ones.
- Beat counter (ATX_LEN_W):
  - m_wlast_o = m_wvalid_o & (cnt == FIFO head length).
  - On each W handshake cnt+1; on a last-beat handshake cnt=0 and pop the FIFO.
  - awlen=0 gives a single beat with WLAST.

B
- m_bready_o = 1 whenever out of reset.
- On m_bvalid_i, look up the valid entry with id==m_bid_i.
- Hit:
  - free the entry; ostd_cnt-1;
  - atx_done[chn] pulses for 1 cycle, registered, the cycle after the handshake;
  - if m_bresp_i[1]==1 (SLVERR/DECERR), set atx_dst_err[chn].
- Miss: response is consumed and dropped, with no state change.
- Accept and B-hit in the same cycle: ostd_cnt unchanged. The accept may reuse the freed entry only on the next cycle.

Error clear
- atx_err_clr[i] clears bit i.
- A set and a clear on the same cycle: set wins.

Counter width: ostd_cnt is clog2(ATX_NUM_OSTD+1) bits and never wraps, because of the accept gating.

Test Plan:
- Single descriptor chn=1, id=3, addr=0x1000, len=3, ready always high -> one AW with those fields; 4 W beats with wlast on beat 4 only; B id=3 OKAY -> atx_done=4'b0010 for one cycle; err stays 0.
- 4 descriptors ids 0..3, B returned in order 2,0,3,1 -> each hit pulses the correct channel's done bit; ostd_cnt returns to 0; a 5th descriptor is blocked while ostd_cnt=4.
- Second descriptor with the same id as an outstanding one -> atx_rdy=0 until its B arrives, then accepted.
- m_awready_i held low 10 cycles while data is valid -> all W beats of len=1 complete before AW; AW payload stays stable; done still pulses after B.
- B with bresp=2'b10 for chn 2 -> atx_dst_err[2]=1 and sticky; atx_err_clr[2] pulse -> 0; clear together with a new error -> remains 1.
- rst_n asserted mid-burst (beat 2 of len=7) -> all valids drop asynchronously, ostd_cnt=0; after release a fresh len=0 descriptor completes normally with wlast on its single beat.

Source files
------------

// File: rtl/adma_dm_wr_host.sv
// AXI DMA destination write host: queues AW descriptors, streams W with generated WLAST, retires B per channel.
// Latency: AW issues the cycle after accept; W is a combinational pass-through; done pulses the cycle after the B handshake.
// Backpressure: atx_rdy drops when the AW or length FIFO is full, the outstanding limit is reached, or the ID is in flight; W follows m_wready_i.
module adma_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_dat = mem[rd_ptr];
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);

  // Callers never push when full nor pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module adma_dm_wr_host #(
  parameter int DMA_CHN_NUM      = 4,
  parameter int DST_ADDR_W       = 32,
  parameter int ATX_DST_DATA_W   = 256,
  parameter int ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
  parameter int MST_ID_W         = 5,
  parameter int ATX_LEN_W        = 8,
  parameter int ATX_RESP_W       = 2,
  parameter int ATX_NUM_OSTD     = DMA_CHN_NUM,
  localparam int DMA_CHN_NUM_W   = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DMA_CHN_NUM_W-1:0]    atx_chn_id,
  input  logic [MST_ID_W-1:0]         atx_awid,
  input  logic [DST_ADDR_W-1:0]       atx_awaddr,
  input  logic [ATX_LEN_W-1:0]        atx_awlen,
  input  logic [1:0]                  atx_awburst,
  input  logic                        atx_vld,
  output logic                        atx_rdy,
  input  logic [ATX_DST_DATA_W-1:0]   atx_wdata,
  input  logic                        atx_wdata_vld,
  output logic                        atx_wdata_rdy,
  output logic [DMA_CHN_NUM-1:0]      atx_done,
  output logic [DMA_CHN_NUM-1:0]      atx_dst_err,
  input  logic [DMA_CHN_NUM-1:0]      atx_err_clr,
  output logic [MST_ID_W-1:0]         m_awid_o,
  output logic [DST_ADDR_W-1:0]       m_awaddr_o,
  output logic [ATX_LEN_W-1:0]        m_awlen_o,
  output logic [1:0]                  m_awburst_o,
  output logic                        m_awvalid_o,
  input  logic                        m_awready_i,
  output logic [ATX_DST_DATA_W-1:0]   m_wdata_o,
  output logic [ATX_DST_BYTE_AMT-1:0] m_wstrb_o,
  output logic                        m_wlast_o,
  output logic                        m_wvalid_o,
  input  logic                        m_wready_i,
  input  logic [MST_ID_W-1:0]         m_bid_i,
  input  logic [ATX_RESP_W-1:0]       m_bresp_i,
  input  logic                        m_bvalid_i,
  output logic                        m_bready_o
);
  localparam int TW  = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
  localparam int OCW = $clog2(ATX_NUM_OSTD + 1);

  typedef struct packed {
    logic [MST_ID_W-1:0]   id;
    logic [DST_ADDR_W-1:0] addr;
    logic [ATX_LEN_W-1:0]  len;
    logic [1:0]            burst;
  } aw_t;

  aw_t                     aw_in, aw_head;
  logic                    aw_full, aw_empty, len_full, len_empty;
  logic [ATX_LEN_W-1:0]    len_head, beat_cnt;
  logic                    run, acc, w_hs, b_hit, dup, hit;
  logic [OCW-1:0]          ostd_cnt;
  logic [ATX_NUM_OSTD-1:0] trk_vld;
  logic [MST_ID_W-1:0]     trk_id  [ATX_NUM_OSTD];
  logic [DMA_CHN_NUM_W-1:0] trk_chn [ATX_NUM_OSTD];
  logic [TW-1:0]           free_idx, hit_idx;
  logic [DMA_CHN_NUM-1:0]  hit_oh;

  // run holds back handshakes until the first clock after reset release.
  assign m_bready_o = run;
  assign atx_rdy    = run & ~aw_full & ~len_full & (ostd_cnt < OCW'(ATX_NUM_OSTD)) & ~dup;
  assign acc        = atx_vld & atx_rdy;
  assign aw_in      = '{id: atx_awid, addr: atx_awaddr, len: atx_awlen, burst: atx_awburst};

  adma_sync_fifo #(.W($bits(aw_t)), .DEPTH(2)) u_aw_buf (
    .clk(clk), .rst_n(rst_n), .push(acc), .push_dat(aw_in),
    .pop(m_awvalid_o & m_awready_i), .head_dat(aw_head), .full(aw_full), .empty(aw_empty)
  );

  adma_sync_fifo #(.W(ATX_LEN_W), .DEPTH(ATX_NUM_OSTD)) u_len_fifo (
    .clk(clk), .rst_n(rst_n), .push(acc), .push_dat(atx_awlen),
    .pop(w_hs & m_wlast_o), .head_dat(len_head), .full(len_full), .empty(len_empty)
  );

  assign m_awvalid_o = ~aw_empty;
  assign m_awid_o    = aw_head.id;
  assign m_awaddr_o  = aw_head.addr;
  assign m_awlen_o   = aw_head.len;
  assign m_awburst_o = aw_head.burst;

  // W runs off the length FIFO alone, so data may lead its AW.
  assign m_wvalid_o    = atx_wdata_vld & ~len_empty;
  assign atx_wdata_rdy = m_wready_i & ~len_empty;
  assign m_wdata_o     = atx_wdata;
  assign m_wstrb_o     = '1;
  assign m_wlast_o     = m_wvalid_o & (beat_cnt == len_head);
  assign w_hs          = m_wvalid_o & m_wready_i;

  // Lowest free slot is allocated; IDs are unique so at most one entry hits.
  always_comb begin
    free_idx = '0;
    hit_idx  = '0;
    dup      = 1'b0;
    hit      = 1'b0;
    for (int i = ATX_NUM_OSTD - 1; i >= 0; i--) begin
      if (!trk_vld[i]) free_idx = TW'(i);
      if (trk_vld[i] && trk_id[i] == atx_awid) dup = 1'b1;
      if (trk_vld[i] && trk_id[i] == m_bid_i) begin
        hit     = 1'b1;
        hit_idx = TW'(i);
      end
    end
  end

  assign b_hit  = m_bvalid_i & m_bready_o & hit;
  assign hit_oh = DMA_CHN_NUM'(1) << trk_chn[hit_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      beat_cnt    <= '0;
      ostd_cnt    <= '0;
      trk_vld     <= '0;
      atx_done    <= '0;
      atx_dst_err <= '0;
      for (int i = 0; i < ATX_NUM_OSTD; i++) begin
        trk_id[i]  <= '0;
        trk_chn[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (w_hs) beat_cnt <= m_wlast_o ? '0 : beat_cnt + 1'b1;
      if (b_hit) trk_vld[hit_idx] <= 1'b0;
      if (acc) begin
        trk_vld[free_idx] <= 1'b1;
        trk_id[free_idx]  <= atx_awid;
        trk_chn[free_idx] <= atx_chn_id;
      end
      case ({acc, b_hit})
        2'b10:   ostd_cnt <= ostd_cnt + 1'b1;
        2'b01:   ostd_cnt <= ostd_cnt - 1'b1;
        default: ostd_cnt <= ostd_cnt;
      endcase
      atx_done <= b_hit ? hit_oh : '0;
      // SLVERR/DECERR have the upper BRESP bit set; a set beats a same-cycle clear.
      atx_dst_err <= (atx_dst_err & ~atx_err_clr) |
                     ((b_hit && m_bresp_i >= ATX_RESP_W'(2)) ? hit_oh : '0);
    end
  end
endmodule

// File: tb/tb_adma_dm_wr_host.sv
// Directed bench for adma_dm_wr_host: descriptor accept, AW/W/B sequencing, error flags, mid-burst reset.
module tb_adma_dm_wr_host;
  logic         clk;
  logic         rst_n;
  logic [1:0]   atx_chn_id;
  logic [4:0]   atx_awid;
  logic [31:0]  atx_awaddr;
  logic [7:0]   atx_awlen;
  logic [1:0]   atx_awburst;
  logic         atx_vld, atx_rdy;
  logic [255:0] atx_wdata;
  logic         atx_wdata_vld, atx_wdata_rdy;
  logic [3:0]   atx_done, atx_dst_err, atx_err_clr;
  logic [4:0]   m_awid_o;
  logic [31:0]  m_awaddr_o;
  logic [7:0]   m_awlen_o;
  logic [1:0]   m_awburst_o;
  logic         m_awvalid_o, m_awready_i;
  logic [255:0] m_wdata_o;
  logic [31:0]  m_wstrb_o;
  logic         m_wlast_o, m_wvalid_o, m_wready_i;
  logic [4:0]   m_bid_i;
  logic [1:0]   m_bresp_i;
  logic         m_bvalid_i, m_bready_o;

  int n_vec = 0;
  int n_err = 0;

  adma_dm_wr_host dut (
    .clk(clk), .rst_n(rst_n),
    .atx_chn_id(atx_chn_id), .atx_awid(atx_awid), .atx_awaddr(atx_awaddr),
    .atx_awlen(atx_awlen), .atx_awburst(atx_awburst), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .atx_wdata(atx_wdata), .atx_wdata_vld(atx_wdata_vld), .atx_wdata_rdy(atx_wdata_rdy),
    .atx_done(atx_done), .atx_dst_err(atx_dst_err), .atx_err_clr(atx_err_clr),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
    .m_awburst_o(m_awburst_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [1:0] chn, input logic [4:0] id,
                           input logic [31:0] addr, input logic [7:0] len);
    bit done_flag;
    done_flag   = 1'b0;
    atx_chn_id  = chn;
    atx_awid    = id;
    atx_awaddr  = addr;
    atx_awlen   = len;
    atx_awburst = 2'b01;
    atx_vld     = 1'b1;
    for (int k = 0; k < 50 && !done_flag; k++) begin
      #1;
      if (atx_rdy) done_flag = 1'b1;
      tick();
    end
    atx_vld = 1'b0;
    if (!done_flag) check("desc_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic w_beat(input string tag, input logic [7:0] idx, input logic exp_last);
    atx_wdata     = {8{24'ha5c300, idx}};
    atx_wdata_vld = 1'b1;
    #1;
    check({tag, "_wvalid"}, 64'(m_wvalid_o), 64'd1);
    check({tag, "_wlast"}, 64'(m_wlast_o), 64'(exp_last));
    check({tag, "_wdata"}, m_wdata_o[255:192], {2{24'ha5c300, idx}});
    tick();
    atx_wdata_vld = 1'b0;
  endtask

  task automatic b_resp(input string tag, input logic [4:0] id, input logic [1:0] resp,
                        input logic [3:0] exp_done);
    m_bid_i    = id;
    m_bresp_i  = resp;
    m_bvalid_i = 1'b1;
    tick();
    m_bvalid_i = 1'b0;
    check({tag, "_done"}, 64'(atx_done), 64'(exp_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; atx_chn_id = '0; atx_awid = '0; atx_awaddr = '0; atx_awlen = '0;
    atx_awburst = '0; atx_vld = 1'b1; atx_wdata = '0; atx_wdata_vld = 1'b1; atx_err_clr = '0;
    m_awready_i = 1'b1; m_wready_i = 1'b1; m_bid_i = '0; m_bresp_i = '0; m_bvalid_i = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_awvalid", 64'(m_awvalid_o), 64'd0);
    check("rst_wvalid", 64'(m_wvalid_o), 64'd0);
    check("rst_wlast", 64'(m_wlast_o), 64'd0);
    check("rst_bready", 64'(m_bready_o), 64'd0);
    check("rst_rdy", 64'(atx_rdy), 64'd0);
    check("rst_done", 64'(atx_done), 64'd0);
    check("rst_err", 64'(atx_dst_err), 64'd0);
    atx_vld = 1'b0; atx_wdata_vld = 1'b0;
    rst_n = 1'b1;
    atx_vld = 1'b1;
    #1;
    check("rdy_before_first_clk", 64'(atx_rdy), 64'd0);
    check("bready_before_first_clk", 64'(m_bready_o), 64'd0);
    atx_vld = 1'b0;
    tick();
    check("bready_after_release", 64'(m_bready_o), 64'd1);

    // Single descriptor, len=3
    send_desc(2'd1, 5'd3, 32'h1000, 8'd3);
    check("t1_awvalid", 64'(m_awvalid_o), 64'd1);
    check("t1_awid", 64'(m_awid_o), 64'd3);
    check("t1_awaddr", 64'(m_awaddr_o), 64'h1000);
    check("t1_awlen", 64'(m_awlen_o), 64'd3);
    check("t1_awburst", 64'(m_awburst_o), 64'd1);
    check("t1_wstrb", 64'(m_wstrb_o), 64'hffff_ffff);
    for (int i = 0; i < 4; i++) w_beat("t1_beat", 8'(i), i == 3);
    check("t1_aw_popped", 64'(m_awvalid_o), 64'd0);
    atx_wdata_vld = 1'b1;
    #1;
    check("t1_w_gated", 64'(m_wvalid_o), 64'd0);
    check("t1_wrdy_gated", 64'(atx_wdata_rdy), 64'd0);
    atx_wdata_vld = 1'b0;
    b_resp("t1_b", 5'd3, 2'b00, 4'b0010);
    tick();
    check("t1_done_one_cycle", 64'(atx_done), 64'd0);
    check("t1_err", 64'(atx_dst_err), 64'd0);

    // Four outstanding, out-of-order B
    for (int i = 0; i < 4; i++) send_desc(2'(i), 5'(i), 32'h100 * i, 8'd0);
    for (int i = 0; i < 4; i++) w_beat("t2_beat", 8'(i + 16), 1'b1);
    atx_awid = 5'd4; atx_chn_id = 2'd0; atx_vld = 1'b1;
    #1;
    check("t2_ostd_block", 64'(atx_rdy), 64'd0);
    atx_vld = 1'b0;
    b_resp("t2_b2", 5'd2, 2'b00, 4'b0100);
    b_resp("t2_b0", 5'd0, 2'b00, 4'b0001);
    b_resp("t2_b3", 5'd3, 2'b00, 4'b1000);
    b_resp("t2_b1", 5'd1, 2'b00, 4'b0010);
    b_resp("t2_bmiss", 5'd7, 2'b10, 4'b0000);
    check("t2_miss_err", 64'(atx_dst_err), 64'd0);
    for (int i = 0; i < 4; i++) send_desc(2'(i), 5'(i + 20), 32'h0, 8'd0);
    atx_awid = 5'd24; atx_vld = 1'b1;
    #1;
    check("t2_refill_block", 64'(atx_rdy), 64'd0);
    atx_vld = 1'b0;
    for (int i = 0; i < 4; i++) w_beat("t2_refill_beat", 8'(i), 1'b1);
    for (int i = 0; i < 4; i++) b_resp("t2_refill_b", 5'(i + 20), 2'b00, 4'(1 << i));

    // Duplicate ID blocked until its B
    send_desc(2'd0, 5'd5, 32'h3000, 8'd0);
    w_beat("t3_beat", 8'h33, 1'b1);
    atx_chn_id = 2'd2; atx_awid = 5'd5; atx_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_dup_block", 64'(atx_rdy), 64'd0);
      tick();
    end
    m_bid_i = 5'd5; m_bresp_i = 2'b00; m_bvalid_i = 1'b1;
    #1;
    check("t3_dup_same_cycle", 64'(atx_rdy), 64'd0);
    tick();
    m_bvalid_i = 1'b0;
    check("t3_b_done", 64'(atx_done), 64'b0001);
    check("t3_dup_release", 64'(atx_rdy), 64'd1);
    tick();
    atx_vld = 1'b0;
    w_beat("t3_beat2", 8'h34, 1'b1);
    b_resp("t3_b2", 5'd5, 2'b00, 4'b0100);

    // W ahead of a stalled AW
    m_awready_i = 1'b0;
    send_desc(2'd3, 5'd9, 32'h2000, 8'd1);
    for (int c = 0; c < 10; c++) begin
      atx_wdata_vld = (c < 2);
      atx_wdata = {8{24'h0, 8'(c)}};
      #1;
      check("t4_awvalid", 64'(m_awvalid_o), 64'd1);
      check("t4_awaddr", 64'(m_awaddr_o), 64'h2000);
      check("t4_awlen", 64'(m_awlen_o), 64'd1);
      if (c < 2) check("t4_wlast", 64'(m_wlast_o), 64'(c == 1));
      else       check("t4_w_drained", 64'(m_wvalid_o), 64'd0);
      tick();
    end
    atx_wdata_vld = 1'b0;
    m_awready_i = 1'b1;
    tick();
    check("t4_aw_issued", 64'(m_awvalid_o), 64'd0);
    b_resp("t4_b", 5'd9, 2'b00, 4'b1000);

    // Sticky error flags
    send_desc(2'd2, 5'd10, 32'h0, 8'd0);
    w_beat("t5_beat", 8'h50, 1'b1);
    b_resp("t5_slverr", 5'd10, 2'b10, 4'b0100);
    check("t5_err_set", 64'(atx_dst_err), 64'b0100);
    tick(); tick();
    check("t5_err_sticky", 64'(atx_dst_err), 64'b0100);
    atx_err_clr = 4'b0100;
    tick();
    atx_err_clr = 4'b0000;
    check("t5_err_clr", 64'(atx_dst_err), 64'd0);
    send_desc(2'd1, 5'd12, 32'h0, 8'd0);
    w_beat("t5_beat_exok", 8'h51, 1'b1);
    b_resp("t5_exokay", 5'd12, 2'b01, 4'b0010);
    check("t5_exokay_noerr", 64'(atx_dst_err), 64'd0);
    send_desc(2'd2, 5'd11, 32'h0, 8'd0);
    w_beat("t5_beat2", 8'h52, 1'b1);
    atx_err_clr = 4'b0100;
    b_resp("t5_decerr", 5'd11, 2'b11, 4'b0100);
    atx_err_clr = 4'b0000;
    check("t5_set_wins", 64'(atx_dst_err), 64'b0100);

    // Reset mid-burst
    m_awready_i = 1'b0;
    send_desc(2'd1, 5'd13, 32'h4000, 8'd7);
    w_beat("t6_beat0", 8'h60, 1'b0);
    w_beat("t6_beat1", 8'h61, 1'b0);
    atx_wdata_vld = 1'b1;
    #1;
    check("t6_pre_rst_wvalid", 64'(m_wvalid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wvalid", 64'(m_wvalid_o), 64'd0);
    check("t6_rst_awvalid", 64'(m_awvalid_o), 64'd0);
    check("t6_rst_bready", 64'(m_bready_o), 64'd0);
    check("t6_rst_err", 64'(atx_dst_err), 64'd0);
    atx_wdata_vld = 1'b0;
    m_awready_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_no_done", 64'(atx_done), 64'd0);
    send_desc(2'd0, 5'd13, 32'h5000, 8'd0);
    check("t6_awid", 64'(m_awid_o), 64'd13);
    check("t6_awaddr", 64'(m_awaddr_o), 64'h5000);
    w_beat("t6_single", 8'h70, 1'b1);
    b_resp("t6_b", 5'd13, 2'b00, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
